load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory-stage front end that sits directly upstream of the word-addressed data memory.
//  Accepts byte/half/word load and store requests from the execute stage over a valid/ready handshake.
//  Converts byte addresses to word indices and performs sub-word stores as read-modify-write.
//  Returns sign- or zero-extended load data, or an error for misaligned accesses, over a valid/ready response channel.
// PARAMETERS
//  ADDRESS_WIDTH  32  width of the byte address on req_addr and of dmem_addr
//  DATA_WIDTH     32  word width; must be 32 (four little-endian byte lanes)
// PORTS
//  clk          in   1     single clock; all state updates on rising edge
//  rst_n        in   1     asynchronous, active-low reset
//  req_valid    in   1     request present
//  req_ready    out  1     unit can accept; high only in IDLE
//  req_we       in   1     1=store, 0=load
//  req_size     in   2     00=byte, 01=half, 10=word, 11=illegal
//  req_unsigned in   1     loads: 1=zero-extend, 0=sign-extend
//  req_addr     in   AW    byte address
//  req_wdata    in   DW    store data, right-justified
//  resp_valid   out  1     response present
//  resp_ready   in   1     consumer takes response
//  resp_rdata   out  DW    extended load data; 0 for stores and errors
//  resp_err     out  1     misaligned access or req_size==11
//  dmem_addr    out  AW    word index = {2'b00, addr[AW-1:2]}
//  dmem_wdata   out  DW    merged write word
//  dmem_we      out  1     write strobe to data memory
//  dmem_rdata   in   DW    combinational read data from data memory
// BEHAVIOUR
//  Reset (async): state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; dmem_we=0; dmem_addr=0; dmem_wdata=0.
//  Accept on rising edge where req_valid&&req_ready; latch all req_* fields; req_ready drops the next cycle.
//  States: IDLE, RD, WR, HOLD, RESP.
//   IDLE -> RESP on accept if misaligned (half: addr[0]!=0; word: addr[1:0]!=0) or size==11; resp_err=1; no memory access.
//   IDLE -> RD   on accept of a load or a byte/half store.
//   IDLE -> WR   on accept of a word store.
//   RD:  drive dmem_addr; capture dmem_rdata into a word register at the end of the cycle. load -> RESP; store -> WR.
//   WR:  dmem_we=1 for exactly one cycle; dmem_wdata = captured word with target lanes replaced (word store: req_wdata).
//   HOLD: dmem_we=0; dmem_addr and dmem_wdata held unchanged (memory acts on both strobe edges); -> RESP.
//   RESP: resp_valid=1; outputs stable until resp_ready; on resp_valid&&resp_ready -> IDLE; req_ready=1 the next cycle.
//  dmem_we is registered and glitch-free; it is never high outside WR.
//  dmem_addr/dmem_wdata change only on entry to RD or WR, and stay stable through HOLD.
//  Lane select = addr[1:0], little-endian. Byte lane k = bits 8k+7:8k. Half lane = addr[1].
//  Load extension: byte -> bit 7 replicated or zeros; half -> bit 15 replicated or zeros; word unchanged.
//  Latency from accept edge to resp_valid:
//   load 2 cycles; word store 3 cycles; sub-word store 4 cycles; error 1 cycle.
//  Back-to-back throughput: one request per (latency + 1) cycles; there is no overlap.
//  Reset asserted mid-operation: immediate return to reset values, and dmem_we falls asynchronously.
//   A store interrupted in WR may leave the target word written; the requester must reissue it.
//  resp_ready held high in IDLE has no effect; a req_valid held through RESP is not accepted until IDLE.
// STRUCTURE
//  lsu_pkg: state enum (IDLE,RD,WR,HOLD,RESP); size localparams SZ_BYTE/SZ_HALF/SZ_WORD/SZ_BAD; lane width constant.
//  Sub-module lsu_lane_align (combinational):
//   inputs: size, offset, unsigned flag, old word, new data.
//   outputs: extended load value, merged store word, misalign flag.
//  Top level contains the FSM, request/response registers and the memory-port registers.
// TESTING
//  1. Word store addr=0x10, data=0xDEADBEEF, then word load 0x10:
//     exactly one dmem_we pulse with dmem_addr=4; resp_rdata=0xDEADBEEF; store resp 3 cycles after accept.
//  2. Memory word 4 = 0x11223344; byte store 0xAA to 0x12:
//     RD then WR; dmem_wdata=0x11AA3344; following load word 0x10 returns 0x11AA3344.
//  3. Memory word = 0x0000F080:
//     signed byte load at offset 0 -> 0xFFFFFF80; unsigned -> 0x00000080;
//     signed half load at offset 0 -> 0xFFFFF080; unsigned -> 0x0000F080.
//  4. Half load at 0x13, word store at 0x12, size=11:
//     each gives resp_err=1 after 1 cycle, resp_rdata=0, dmem_we never asserts.
//  5. resp_ready held low for 5 cycles in RESP:
//     resp_* stable, req_ready=0, new req_valid ignored; completes when resp_ready rises.
//  6. rst_n asserted during WR of a store:
//     dmem_we drops with no clock edge; all outputs at reset values; first request after release completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
//   lsu_state_e : FSM states
//   SZ_*        : req_size encodings
//   LANE_W      : width of one byte lane
//   WORD_W      : data word width (four little-endian lanes)
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        HOLD = 3'd3,
        RESP = 3'd4
    } lsu_state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    localparam int unsigned LANE_W = 8;
    localparam int unsigned WORD_W = 4 * LANE_W;

endpackage

// File: rtl/lsu_if.sv
// Request/response channel between the execute stage and the load/store unit.
//   master : execute stage (drives req_*, resp_ready)
//   slave  : load/store unit (drives req_ready, resp_*)
interface lsu_if #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_we;
    logic [1:0]               req_size;
    logic                     req_unsigned;
    logic [ADDRESS_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0]    req_wdata;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [DATA_WIDTH-1:0]    resp_rdata;
    logic                     resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for sub-word accesses.
//   size, offset, is_unsigned : access descriptor
//   old_word                  : word read from memory
//   new_data                  : right-justified store data
//   load_val                  : extracted and extended load value
//   store_word                : old_word with the target lanes replaced
//   misalign                  : access not naturally aligned or illegal size
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        offset,
    input  logic              is_unsigned,
    input  logic [WORD_W-1:0] old_word,
    input  logic [WORD_W-1:0] new_data,
    output logic [WORD_W-1:0] load_val,
    output logic [WORD_W-1:0] store_word,
    output logic              misalign
);
    logic [4:0]        shamt;
    logic [WORD_W-1:0] shifted;
    logic [WORD_W-1:0] mask;

    assign shamt   = {offset, 3'b000};
    assign shifted = old_word >> shamt;

    // Load extraction and extension
    always_comb begin
        load_val = old_word;
        case (size)
            SZ_BYTE: load_val = is_unsigned ? {24'h0, shifted[7:0]}
                                            : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_val = is_unsigned ? {16'h0, shifted[15:0]}
                                            : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = old_word;
        endcase
    end

    // Store merge: replace only the lanes covered by the access
    always_comb begin
        mask = '1;
        case (size)
            SZ_BYTE: mask = WORD_W'(32'h0000_00FF) << shamt;
            SZ_HALF: mask = WORD_W'(32'h0000_FFFF) << shamt;
            default: mask = '1;
        endcase
    end

    assign store_word = (old_word & ~mask) | ((new_data << shamt) & mask);

    assign misalign = (size == SZ_BAD)
                    | ((size == SZ_HALF) & offset[0])
                    | ((size == SZ_WORD) & (offset != 2'b00));
endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store front end for a word-addressed data memory.
//   clk, rst_n : clock, async active-low reset
//   bus        : execute-stage request/response channel (slave side)
//   dmem_addr  : word index to data memory
//   dmem_wdata : merged write word
//   dmem_we    : single-cycle write strobe
//   dmem_rdata : combinational read data from data memory
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    lsu_if.slave                     bus,
    output logic [ADDRESS_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0]    dmem_wdata,
    output logic                     dmem_we,
    input  logic [DATA_WIDTH-1:0]    dmem_rdata
);
    lsu_state_e            state;
    logic                  req_ready;
    logic                  resp_valid;
    logic                  resp_err;
    logic [DATA_WIDTH-1:0] resp_rdata;

    logic                  lat_we;
    logic [1:0]            lat_size;
    logic                  lat_uns;
    logic [1:0]            lat_off;
    logic [DATA_WIDTH-1:0] lat_wdata;

    logic [1:0]            al_size;
    logic [1:0]            al_off;
    logic [DATA_WIDTH-1:0] load_val;
    logic [DATA_WIDTH-1:0] store_word;
    logic                  misalign;

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_err   = resp_err;
    assign bus.resp_rdata = resp_rdata;

    // Alignment is judged on the live request in IDLE, on latched fields afterwards
    assign al_size = (state == IDLE) ? bus.req_size        : lat_size;
    assign al_off  = (state == IDLE) ? bus.req_addr[1:0]   : lat_off;

    lsu_lane_align u_align (
        .size        (al_size),
        .offset      (al_off),
        .is_unsigned (lat_uns),
        .old_word    (dmem_rdata),
        .new_data    (lat_wdata),
        .load_val    (load_val),
        .store_word  (store_word),
        .misalign    (misalign)
    );

    // Control FSM with registered request, response and memory-port outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            lat_we     <= 1'b0;
            lat_size   <= SZ_BYTE;
            lat_uns    <= 1'b0;
            lat_off    <= 2'b00;
            lat_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && req_ready) begin
                        lat_we    <= bus.req_we;
                        lat_size  <= bus.req_size;
                        lat_uns   <= bus.req_unsigned;
                        lat_off   <= bus.req_addr[1:0];
                        lat_wdata <= bus.req_wdata;
                        req_ready <= 1'b0;
                        if (misalign) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= RESP;
                        end else begin
                            dmem_addr <= {2'b00, bus.req_addr[ADDRESS_WIDTH-1:2]};
                            if (bus.req_we && (bus.req_size == SZ_WORD)) begin
                                // Full-word store needs no read
                                dmem_wdata <= bus.req_wdata;
                                dmem_we    <= 1'b1;
                                state      <= WR;
                            end else begin
                                state <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    if (lat_we) begin
                        dmem_wdata <= store_word;
                        dmem_we    <= 1'b1;
                        state      <= WR;
                    end else begin
                        resp_rdata <= load_val;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                WR: begin
                    dmem_we <= 1'b0;
                    state   <= HOLD;
                end
                HOLD: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a small word memory model.
module tb_load_store_unit;
    logic        clk;
    logic        rst_n;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_we;
    logic [31:0] dmem_rdata;
    logic [31:0] mem [0:63];

    int n_vec;
    int n_bad;

    int          r_lat;
    int          r_pulses;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_waddr;
    logic [31:0] r_wdata;

    lsu_if bus ();

    load_store_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_we    (dmem_we),
        .dmem_rdata (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dmem_rdata = mem[dmem_addr[5:0]];
    always @(posedge clk) if (dmem_we) mem[dmem_addr[5:0]] <= dmem_wdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request; optionally stall resp_ready for 'hold' cycles while a stray request is offered
    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata, input int hold);
        int          cyc;
        logic [31:0] snap;
        @(negedge clk);
        check_eq("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        cyc      = 1;
        r_pulses = 0;
        r_waddr  = 32'hx;
        r_wdata  = 32'hx;
        while (1) begin
            if (dmem_we) begin
                r_pulses++;
                r_waddr = dmem_addr;
                r_wdata = dmem_wdata;
            end
            if (bus.resp_valid || cyc >= 12) break;
            @(posedge clk); #1;
            cyc++;
        end
        if (!bus.resp_valid) check_eq("resp_timeout", 32'(bus.resp_valid), 32'd1);
        r_lat   = cyc;
        r_rdata = bus.resp_rdata;
        r_err   = bus.resp_err;
        snap    = bus.resp_rdata;
        for (int i = 0; i < hold; i++) begin
            if (i == 0) begin
                bus.req_valid = 1'b1;
                bus.req_we    = 1'b1;
                bus.req_size  = 2'b10;
                bus.req_addr  = 32'h10;
                bus.req_wdata = 32'h0BAD_0BAD;
            end
            @(posedge clk); #1;
            check_eq("hold_resp_valid", 32'(bus.resp_valid), 32'd1);
            check_eq("hold_resp_rdata", bus.resp_rdata, snap);
            check_eq("hold_req_ready", 32'(bus.req_ready), 32'd0);
            check_eq("hold_dmem_we", 32'(dmem_we), 32'd0);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        check_eq("resp_valid_drop", 32'(bus.resp_valid), 32'd0);
        check_eq("req_ready_back", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"},  32'(bus.req_ready),  32'd1);
        check_eq({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        check_eq({tag, "_resp_err"},   32'(bus.resp_err),   32'd0);
        check_eq({tag, "_resp_rdata"}, bus.resp_rdata,      32'd0);
        check_eq({tag, "_dmem_we"},    32'(dmem_we),        32'd0);
        check_eq({tag, "_dmem_addr"},  dmem_addr,           32'd0);
        check_eq({tag, "_dmem_wdata"}, dmem_wdata,          32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        rst_n            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.resp_ready   = 1'b1;
        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n          = 1'b1;
        bus.resp_ready = 1'b0;

        // Word store then word load
        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 0);
        check_eq("sw_lat", 32'(r_lat), 32'd3);
        check_eq("sw_pulses", 32'(r_pulses), 32'd1);
        check_eq("sw_addr", r_waddr, 32'd4);
        check_eq("sw_wdata", r_wdata, 32'hDEAD_BEEF);
        check_eq("sw_rdata", r_rdata, 32'd0);
        check_eq("sw_err", 32'(r_err), 32'd0);
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
        check_eq("lw_lat", 32'(r_lat), 32'd2);
        check_eq("lw_pulses", 32'(r_pulses), 32'd0);
        check_eq("lw_rdata", r_rdata, 32'hDEAD_BEEF);

        // Byte store merge, then half store merge
        mem[4] = 32'h1122_3344;
        run_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00AA, 0);
        check_eq("sb_lat", 32'(r_lat), 32'd4);
        check_eq("sb_pulses", 32'(r_pulses), 32'd1);
        check_eq("sb_addr", r_waddr, 32'd4);
        check_eq("sb_wdata", r_wdata, 32'h11AA_3344);
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
        check_eq("sb_readback", r_rdata, 32'h11AA_3344);
        run_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_5566, 0);
        check_eq("sh_lat", 32'(r_lat), 32'd4);
        check_eq("sh_wdata", r_wdata, 32'h5566_3344);
        run_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 0);
        check_eq("lhu_hi", r_rdata, 32'h0000_5566);

        // Load extension
        mem[5] = 32'h0000_F080;
        run_req(1'b0, 2'b00, 1'b0, 32'h14, 32'h0, 0);
        check_eq("lb_s", r_rdata, 32'hFFFF_FF80);
        run_req(1'b0, 2'b00, 1'b1, 32'h14, 32'h0, 0);
        check_eq("lb_u", r_rdata, 32'h0000_0080);
        run_req(1'b0, 2'b01, 1'b0, 32'h14, 32'h0, 0);
        check_eq("lh_s", r_rdata, 32'hFFFF_F080);
        run_req(1'b0, 2'b01, 1'b1, 32'h14, 32'h0, 0);
        check_eq("lh_u", r_rdata, 32'h0000_F080);
        run_req(1'b0, 2'b00, 1'b0, 32'h15, 32'h0, 0);
        check_eq("lb_s_lane1", r_rdata, 32'hFFFF_FFF0);

        // Error cases
        run_req(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 0);
        check_eq("err_lh_lat", 32'(r_lat), 32'd1);
        check_eq("err_lh_err", 32'(r_err), 32'd1);
        check_eq("err_lh_rdata", r_rdata, 32'd0);
        check_eq("err_lh_pulses", 32'(r_pulses), 32'd0);
        run_req(1'b1, 2'b10, 1'b0, 32'h12, 32'hFFFF_FFFF, 0);
        check_eq("err_sw_lat", 32'(r_lat), 32'd1);
        check_eq("err_sw_err", 32'(r_err), 32'd1);
        check_eq("err_sw_pulses", 32'(r_pulses), 32'd0);
        run_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0);
        check_eq("err_sz_lat", 32'(r_lat), 32'd1);
        check_eq("err_sz_err", 32'(r_err), 32'd1);
        check_eq("err_sz_rdata", r_rdata, 32'd0);

        // Response back-pressure with a stray request offered
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5);
        check_eq("bp_rdata", r_rdata, 32'h5566_3344);
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
        check_eq("bp_no_store", r_rdata, 32'h5566_3344);

        // Reset in the middle of a sub-word store's WR cycle
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'b00;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'h77;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("mid_wr_we", 32'(dmem_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
        check_eq("post_rst_lat", 32'(r_lat), 32'd2);
        check_eq("post_rst_rdata", r_rdata, 32'h5566_3344);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
